round_divider: RTL
==================

Name: round_divider

Overview:
- Iterative restoring divider coprocessor. Computes the rounded fixed-point quotient round(N·2^FS / D) that the 1/x and divide programs produce in software.
- Sits beside the datapath of TopLevel and is fed operands loaded from data memory.
- Output is the value that is written back to the result bytes.
- One quotient bit per cycle. Half-LSB upward rounding. Saturating divide-by-zero.

Parameters:
- NW, 16, dividend width in bits.
- DW, 8, divisor width in bits.
- FS, 8, fraction shift applied to the dividend. Result width QW = NW+FS is a derived localparam, not overridable.

Ports:
- CLK  input  1  system clock; only clock in the block.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  launch request; level signal, acted on at its rising edge.
- dividend  input  NW  N, unsigned; sampled on launch only.
- divisor  input  DW  D, unsigned; sampled on launch only.
- busy  output  1  high while in CALC or ROUND.
- done  output  1  high in DONE; result valid while high.
- result  output  QW  rounded quotient.

Behaviour:
- Reset value of every output: busy=0, done=0, result=0. Internal start_q=0, state=IDLE. Reset applies at any cycle and aborts an operation in progress with no residue.
- launch = start & ~start_q, with start_q registered every cycle. launch is honoured only in IDLE or DONE; ignored in CALC and ROUND. start held high for many cycles launches once.
- States: IDLE, CALC, ROUND, DONE.
- IDLE/DONE with launch and D≠0:
  - capture N and D;
  - load shift register X = N << (FS+1), width QW+1;
  - partial remainder P = 0, width DW+1;
  - quotient register R = 0, width QW+1;
  - counter = QW+1;
  - done←0, busy←1, state→CALC.
- IDLE/DONE with launch and D=0: result←all ones (saturate), done←1, state→DONE on the next edge. CALC is skipped.
- CALC, per cycle:
  - T = {P[DW-1:0], X msb}; X shifts left 1.
  - If T ≥ D: P←T−D and shift 1 into R. Else P←T and shift 0 into R.
  - Decrement counter; when it reaches 0 after the final bit, go to ROUND. Exactly QW+1 CALC cycles.
- ROUND (1 cycle): result ← (R[QW:1] + R[0]) mod 2^QW. busy←0, done←1, state→DONE.
- DONE: result and done held stable until the next launch or Reset.
- Latency: launch sampled at edge 0 → done visible after edge QW+3. Default params: 27 cycles. D=0: 1 cycle.
- Previous result stays on the port after a new launch until the next ROUND. done is the only validity indicator.
- Arithmetic is unsigned throughout. Overflow in ROUND cannot occur for legal inputs (max N·2^FS fits QW bits); modulo wrap is still specified.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined: adds port `rem  output  DW`, reset 0. Loaded in ROUND with P[DW-1:0], equal to (N·2^(FS+1)) mod D. Forced to 0 on the D=0 path. Valid with done.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Defaults, N=403, D=129 → done after 27 cycles, result=24'h000320. With DIV_REMAINDER_EN, rem=8'd65.
- Defaults, N=257, D=129 → result=24'h0001FE. Then N=65535, D=1 → result=24'hFFFF00. Both with busy high exactly 26 cycles.
- Defaults, D=0, any N → done one cycle after launch, result=24'hFFFFFF, busy never asserted.
- NW=16, DW=16, FS=0: N=16'h8000, D=3 → result=16'h2AAB. D=16'h8000 → 16'h0001. D=16'hFFFF → 16'h0001.
- start held high across launch, CALC and DONE → exactly one operation. Low then high while in DONE → second operation launches, done drops next cycle. Rising edge during CALC → ignored, result unaffected.
- Reset asserted for 1 cycle mid-CALC → next cycle busy=0, done=0, result=0, state IDLE. A fresh launch then gives the correct result.

Source files
------------

// File: rtl/round_divider_if.sv
// Handshake/operand bundle for round_divider; the rem signal exists only when
// DIV_REMAINDER_EN is defined.
interface round_divider_if #(
    parameter int NW = 16,
    parameter int DW = 8,
    parameter int FS = 8
);
    localparam int QW = NW + FS;

    logic          start;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] result;
`ifdef DIV_REMAINDER_EN
    logic [DW-1:0] rem;
`endif

    modport master (
        output start, dividend, divisor,
        input  busy, done, result
`ifdef DIV_REMAINDER_EN
        , input rem
`endif
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, result
`ifdef DIV_REMAINDER_EN
        , output rem
`endif
    );
endinterface

// File: rtl/round_divider.sv
// Iterative restoring divider producing round(N*2^FS / D), one quotient bit per cycle.
// Optional DIV_REMAINDER_EN adds the final partial remainder on the rem port.
module round_divider #(
    parameter int NW = 16,
    parameter int DW = 8,
    parameter int FS = 8
) (
    input logic             CLK,
    input logic             Reset,
    round_divider_if.slave  bus
);
    localparam int QW = NW + FS;
    localparam int CW = $clog2(QW + 2);

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t        state, state_nxt;
    logic          start_q;
    logic          launch;
    logic          div_zero;
    logic [CW-1:0] cnt;
    logic [QW:0]   x_sh;
    logic [DW-1:0] p_rem;
    logic [QW:0]   r_quo;
    logic [DW-1:0] d_cap;
    logic [DW:0]   t_trial;
    logic          t_ge;
    logic [QW-1:0] result_q;

    // Quotient carries one extra fraction bit; add it back as the half-LSB round-up.
    function automatic logic [QW-1:0] round_half_up(input logic [QW:0] q);
        return q[QW:1] + QW'(q[0]);
    endfunction

    assign launch   = bus.start & ~start_q;
    assign div_zero = (bus.divisor == '0);
    assign t_trial  = {p_rem, x_sh[QW]};
    assign t_ge     = (t_trial >= {1'b0, d_cap});

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (launch) state_nxt = div_zero ? DONE : CALC;
            CALC:       if (cnt == CW'(1)) state_nxt = ROUND;
            ROUND:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Control and visible outputs: reset to zero, aborting any operation.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            start_q  <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        if (div_zero) result_q <= '1;
                        else          cnt      <= CW'(QW + 1);
                    end
                end
                CALC:    cnt      <= cnt - CW'(1);
                ROUND:   result_q <= round_half_up(r_quo);
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on launch.
    always_ff @(posedge CLK) begin
        case (state)
            IDLE, DONE: begin
                if (launch && !div_zero) begin
                    d_cap <= bus.divisor;
                    x_sh  <= {bus.dividend, {(FS + 1){1'b0}}};
                    p_rem <= '0;
                    r_quo <= '0;
                end
            end
            CALC: begin
                x_sh  <= {x_sh[QW-1:0], 1'b0};
                p_rem <= t_ge ? DW'(t_trial - {1'b0, d_cap}) : DW'(t_trial);
                r_quo <= {r_quo[QW-1:0], t_ge};
            end
            default: ;
        endcase
    end

`ifdef DIV_REMAINDER_EN
    logic [DW-1:0] rem_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rem_q <= '0;
        end else if ((state == IDLE || state == DONE) && launch && div_zero) begin
            rem_q <= '0;
        end else if (state == ROUND) begin
            rem_q <= p_rem;
        end
    end

    assign bus.rem = rem_q;
`endif

    assign bus.busy   = (state == CALC) || (state == ROUND);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule
